// File: rtl/denise_bitplane_deshifter_pkg.sv
// Shared definitions for the Denise bitplane deshifter.
// Covers fetch-mode encodings, word length and skip mask per mode, and the capture FSM states.
package denise_bitplane_deshifter_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        FMODE_X1  = 2'b00,
        FMODE_X2A = 2'b01,
        FMODE_X2B = 2'b10,
        FMODE_X4  = 2'b11
    } fmode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic [6:0] WORD_LEN_X1 = 7'd16;
    localparam logic [6:0] WORD_LEN_X2 = 7'd32;
    localparam logic [6:0] WORD_LEN_X4 = 7'd64;

    localparam logic [5:0] SKIP_MASK_X1 = 6'h0F;
    localparam logic [5:0] SKIP_MASK_X2 = 6'h1F;
    localparam logic [5:0] SKIP_MASK_X4 = 6'h3F;

    function automatic logic [6:0] word_len(input fmode_e f);
        case (f)
            FMODE_X1:             return WORD_LEN_X1;
            FMODE_X2A, FMODE_X2B: return WORD_LEN_X2;
            default:              return WORD_LEN_X4;
        endcase
    endfunction

    function automatic logic [5:0] skip_mask(input fmode_e f);
        case (f)
            FMODE_X1:             return SKIP_MASK_X1;
            FMODE_X2A, FMODE_X2B: return SKIP_MASK_X2;
            default:              return SKIP_MASK_X4;
        endcase
    endfunction

endpackage

// File: rtl/denise_bitplane_deshifter_fifo.sv
// Two-entry output buffer for assembled bitplane words.
// A push while full is accepted only if the head is popped in the same cycle.
module denise_bitplane_deshifter_fifo
    import denise_bitplane_deshifter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop;
    logic              accept;

    assign full      = (count_q == 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    assign accept    = push & (~full | pop);

    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, accept} - {1'b0, pop};
    end

    // NOTE: storage is reset too, so out_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/denise_bitplane_deshifter.sv
// Collects a serial bitplane stream into left-aligned 16/32/64-bit words.
// Leading scroll pixels are skipped, and each finished word goes out through a two-entry buffer.
module denise_bitplane_deshifter
    import denise_bitplane_deshifter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk7_en,
    input  logic              c1,
    input  logic              c3,
    input  logic              hires,
    input  logic              shres,
    input  logic [1:0]        fmode,
    input  logic [7:0]        scroll,
    input  logic              start,
    input  logic              stop,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              ovf_clr
);

    state_e            state_q, state_d;
    logic              hires_q, hires_d;
    logic              shres_q, shres_d;
    fmode_e            fmode_q, fmode_d;
    logic [5:0]        skip_q, skip_d;
    logic [5:0]        skip_raw, skip_sel;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_n;
    logic [DATA_W-1:0] asm_q, asm_d, asm_n;
    logic              ovf_q, ovf_d;
    logic              strobe;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              fifo_full;
    logic              drop;
    logic              unused_clk7_en;

    // The pixel phase comes entirely from c1/c3, so the 7 MHz enable is not needed here.
    assign unused_clk7_en = clk7_en;

    always_comb begin
        if (shres_q)      strobe = 1'b1;
        else if (hires_q) strobe = ~c1 ^ c3;
        else              strobe = ~c1 & ~c3;
    end

    always_comb begin
        if (shres)      skip_raw = scroll[5:0];
        else if (hires) skip_raw = scroll[6:1];
        else            skip_raw = scroll[7:2];
        skip_sel = skip_raw & skip_mask(fmode_e'(fmode));
    end

    always_comb begin
        state_d   = state_q;
        hires_d   = hires_q;
        shres_d   = shres_q;
        fmode_d   = fmode_q;
        skip_d    = skip_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        cnt_n     = cnt_q;
        asm_n     = asm_q;
        push      = 1'b0;
        push_data = asm_q;

        case (state_q)
            ST_SKIP: begin
                if (strobe) begin
                    skip_d = skip_q - 6'd1;
                    if (skip_q == 6'd1) state_d = ST_CAPTURE;
                end
                if (stop) state_d = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (strobe) begin
                    asm_n[6'd63 - cnt_q] = in;
                    if (({1'b0, cnt_q} + 7'd1) == word_len(fmode_q)) begin
                        push      = 1'b1;
                        push_data = asm_n;
                        asm_n     = '0;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt_q + 6'd1;
                    end
                end
                asm_d = asm_n;
                cnt_d = cnt_n;
                // A bit strobed in the stop cycle is already in asm_n, so the flush includes it.
                if (stop) begin
                    if (cnt_n != '0) begin
                        push      = 1'b1;
                        push_data = asm_n;
                    end
                    state_d = ST_IDLE;
                    asm_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase

        if (start) begin
            push    = 1'b0;
            hires_d = hires;
            shres_d = shres;
            fmode_d = fmode_e'(fmode);
            skip_d  = skip_sel;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = (skip_sel != 6'd0) ? ST_SKIP : ST_CAPTURE;
        end
    end

    // Only a push the buffer cannot take counts as a drop.
    assign drop = push & fifo_full & ~out_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hires_q <= 1'b0;
            shres_q <= 1'b0;
            fmode_q <= FMODE_X1;
            skip_q  <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hires_q <= hires_d;
            shres_q <= shres_d;
            fmode_q <= fmode_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    denise_bitplane_deshifter_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .full      (fifo_full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_denise_bitplane_deshifter.sv
// Self-checking bench for the bitplane deshifter: a table of capture scenarios plus
// hand-written sequences for latency, overflow, reset and start/stop collisions.
module tb_denise_bitplane_deshifter;

    logic        clk;
    logic        reset_n;
    logic        clk7_en;
    logic        c1;
    logic        c3;
    logic        hires;
    logic        shres;
    logic [1:0]  fmode;
    logic [7:0]  scroll;
    logic        start;
    logic        stop;
    logic        in;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_q[$];

    typedef struct {
        string       name;
        logic        hr;
        logic        sr;
        logic [1:0]  fm;
        logic [7:0]  sc;
        int          junk;
        logic [63:0] data;
        int          nbits;
        logic        with_stop;
        int          exp_n;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    vec_t vecs[8];

    denise_bitplane_deshifter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk7_en   (clk7_en),
        .c1        (c1),
        .c3        (c3),
        .hires     (hires),
        .shres     (shres),
        .fmode     (fmode),
        .scroll    (scroll),
        .start     (start),
        .stop      (stop),
        .in        (in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted output word; inputs settle at the negedge, handshake at the next posedge.
    always begin
        @(negedge clk);
        #1;
        if (reset_n && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return {64{1'bx}};
    endfunction

    function automatic vec_t mk(input string nm, input logic hr, input logic sr,
                                input logic [1:0] fm, input logic [7:0] sc, input int jk,
                                input logic [63:0] d, input int n, input logic st,
                                input int en, input logic [63:0] e0, input logic [63:0] e1);
        vec_t v;
        v.name = nm; v.hr = hr; v.sr = sr; v.fm = fm; v.sc = sc; v.junk = jk;
        v.data = d; v.nbits = n; v.with_stop = st; v.exp_n = en; v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    task automatic cyc(input logic c1v, input logic c3v, input logic inv,
                       input logic sv, input logic pv);
        c1 = c1v; c3 = c3v; in = inv; start = sv; stop = pv;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Junk bits are ones; gap cycles use phase pairs that must not strobe in the current mode.
    task automatic feed(input logic hr, input logic sr, input int junk,
                        input logic [63:0] data, input int n, input logic with_stop);
        for (int k = 0; k < junk + n; k++) begin
            logic b, last, odd, sc1, sc3;
            b    = (k < junk) ? 1'b1 : data[63 - (k - junk)];
            last = with_stop && (k == junk + n - 1);
            odd  = (k % 2 == 1);
            if (!sr && (k % 3 == 1)) begin
                if (hr) cyc(odd, ~odd, ~b, 1'b0, 1'b0);
                else    cyc(odd, 1'b1, ~b, 1'b0, 1'b0);
            end
            sc1 = hr ? odd : 1'b0;
            sc3 = hr ? odd : 1'b0;
            cyc(sc1, sc3, b, 1'b0, last);
        end
    endtask

    task automatic feed_word(input logic [15:0] w, input int nb);
        for (int i = 0; i < nb; i++) cyc(1'b0, 1'b0, w[15 - i], 1'b0, 1'b0);
    endtask

    task automatic set_mode(input logic hr, input logic sr, input logic [1:0] fm, input logic [7:0] sc);
        hires = hr; shres = sr; fmode = fm; scroll = sc;
    endtask

    initial begin
        logic [15:0] w;
        reset_n = 1'b0; clk7_en = 1'b1; c1 = 1'b1; c3 = 1'b0;
        hires = 1'b0; shres = 1'b0; fmode = 2'b00; scroll = 8'h00;
        start = 1'b0; stop = 1'b0; in = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        reset_n = 1'b1;
        idle(2);

        vecs[0] = mk("lores_x1_a5c3", 0, 0, 2'b00, 8'h00, 0, 64'hA5C3_0000_0000_0000, 16, 0,
                     1, 64'hA5C3_0000_0000_0000, 64'd0);
        vecs[1] = mk("hires_x4_skip3", 1, 0, 2'b11, 8'h06, 3, 64'h0123_4567_89AB_CDEF, 64, 0,
                     1, 64'h0123_4567_89AB_CDEF, 64'd0);
        vecs[2] = mk("shres_x2_40ones", 0, 1, 2'b01, 8'h00, 0, 64'hFFFF_FFFF_FF00_0000, 40, 1,
                     2, 64'hFFFF_FFFF_0000_0000, 64'hFF00_0000_0000_0000);
        vecs[3] = mk("lores_x2b_skip3", 0, 0, 2'b10, 8'h0C, 3, 64'hDEAD_BEEF_0000_0000, 32, 0,
                     1, 64'hDEAD_BEEF_0000_0000, 64'd0);
        vecs[4] = mk("hires_mask_0f", 1, 0, 2'b00, 8'hFE, 15, 64'h8001_0000_0000_0000, 16, 0,
                     1, 64'h8001_0000_0000_0000, 64'd0);
        vecs[5] = mk("shres_mask_1f", 0, 1, 2'b01, 8'h21, 1, 64'h1234_5678_9000_0000, 36, 1,
                     2, 64'h1234_5678_0000_0000, 64'h9000_0000_0000_0000);
        vecs[6] = mk("lores_partial12", 0, 0, 2'b11, 8'h00, 0, 64'hABC0_0000_0000_0000, 12, 1,
                     1, 64'hABC0_0000_0000_0000, 64'd0);
        vecs[7] = mk("stop_on_full", 1, 0, 2'b00, 8'h00, 0, 64'hF00F_0000_0000_0000, 16, 1,
                     1, 64'hF00F_0000_0000_0000, 64'd0);

        for (int v = 0; v < 8; v++) begin
            set_mode(vecs[v].hr, vecs[v].sr, vecs[v].fm, vecs[v].sc);
            out_ready = 1'b1;
            got_q.delete();
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            feed(vecs[v].hr, vecs[v].sr, vecs[v].junk, vecs[v].data, vecs[v].nbits, vecs[v].with_stop);
            idle(4);
            check({vecs[v].name, "_count"}, 64'(got_q.size()), 64'(vecs[v].exp_n));
            check({vecs[v].name, "_w0"}, got_at(0), vecs[v].exp0);
            if (vecs[v].exp_n > 1) check({vecs[v].name, "_w1"}, got_at(1), vecs[v].exp1);
        end

        // Push-to-valid latency: visible one clock after the 16th strobe.
        set_mode(0, 0, 2'b00, 8'h00);
        out_ready = 1'b1;
        got_q.delete();
        w = 16'hA5C3;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed_word(w, 15);
        check("lat_before_16th", 64'(out_valid), 64'd0);
        cyc(1'b0, 1'b0, w[0], 1'b0, 1'b0);
        check("lat_after_16th", 64'(out_valid), 64'd1);
        check("lat_data", out_data, 64'hA5C3_0000_0000_0000);
        idle(3);

        // Overflow: two held, third dropped, set beats clear, full push+pop accepted.
        got_q.delete();
        out_ready = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed_word(16'h1111, 16);
        feed_word(16'h2222, 16);
        check("ovf_two_held", 64'(overflow), 64'd0);
        check("ovf_valid_full", 64'(out_valid), 64'd1);
        feed_word(16'h3333, 16);
        check("ovf_third_dropped", 64'(overflow), 64'd1);
        check("ovf_head_kept", out_data, 64'h1111_0000_0000_0000);
        feed_word(16'h4444, 15);
        ovf_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_set_wins", 64'(overflow), 64'd1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        w = 16'h5555;
        feed_word(w, 15);
        out_ready = 1'b1;
        cyc(1'b0, 1'b0, w[0], 1'b0, 1'b0);
        check("full_push_pop_no_ovf", 64'(overflow), 64'd0);
        idle(4);
        check("ovf_drain_count", 64'(got_q.size()), 64'd3);
        check("ovf_drain_w0", got_at(0), 64'h1111_0000_0000_0000);
        check("ovf_drain_w1", got_at(1), 64'h2222_0000_0000_0000);
        check("ovf_drain_w2", got_at(2), 64'h5555_0000_0000_0000);

        // Reset mid-capture with buffered words and overflow set.
        out_ready = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed_word(16'hBEEF, 16);
        feed_word(16'hCAFE, 16);
        feed_word(16'hF00D, 16);
        feed_word(16'hABCD, 10);
        check("pre_rst_overflow", 64'(overflow), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", out_data, 64'd0);
        check("async_rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        idle(3);
        check("no_push_after_release", 64'(out_valid), 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed_word(16'h1234, 16);
        idle(4);
        check("post_rst_count", 64'(got_q.size()), 64'd1);
        check("post_rst_word", got_at(0), 64'h1234_0000_0000_0000);

        // start and stop together mid-word: no push, counter restarts; mode stays latched.
        got_q.delete();
        set_mode(0, 0, 2'b00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        fmode = 2'b11;
        feed_word(16'hFF00, 8);
        fmode = 2'b00;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("start_stop_no_push", 64'(out_valid), 64'd0);
        fmode = 2'b11;
        hires = 1'b1;
        feed_word(16'h0F0F, 16);
        idle(4);
        check("restart_count", 64'(got_q.size()), 64'd1);
        check("restart_word", got_at(0), 64'h0F0F_0000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
